// File: rtl/mem_access.sv
// Memory-access stage: alignment check, byte-lane steering, req/ack data bus,
// load extension, registered writeback and precise load/store fault reports.
module mem_access #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        ma_stall,
    output logic        wbk_rd_reg_wb,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] rd_data_wb,
    output logic        ma_fault,
    output logic [3:0]  ma_fault_cause,
    output logic [31:0] ma_fault_adr,
    output logic        dbg_state
);

    // Bus handshake: dmem_req rises with all bus fields registered and holds them
    // stable until the cycle dmem_ack=1 (ack may arrive in the first req cycle);
    // dmem_ack outside an outstanding request is ignored.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        is_ld, is_st, access, misalign, timeout_hit;
    logic [1:0]  a;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    logic [4:0]  lat_rd;
    logic [2:0]  lat_code;
    logic [1:0]  lat_a;
    logic        lat_wbk, lat_st;
    logic [31:0] lat_eff_adr;

    logic [31:0] rdata_shift, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ma_stall  = (state == BUSY);
    assign dbg_state = state;

    always_comb begin
        is_ld      = cmd_ld_ma;
        is_st      = cmd_st_ma & ~cmd_ld_ma;
        access     = cmd_ld_ma | cmd_st_ma;
        a          = rd_data_ma[1:0];
        misalign   = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = st_data_ma;
        case (ldst_code_ma)
            3'b000:  misalign = 1'b0;
            3'b001:  misalign = a[0];
            3'b010:  misalign = (a != 2'b00);
            3'b100:  misalign = is_st;
            3'b101:  misalign = is_st | a[0];
            default: misalign = 1'b1;
        endcase
        case (ldst_code_ma[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << a;
                wdata_calc = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {a[1], 1'b0};
                wdata_calc = {2{st_data_ma[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = st_data_ma;
            end
        endcase
    end

    // Lane select uses the byte offset latched at request time.
    always_comb begin
        rdata_shift = dmem_rdata >> {lat_a, 3'b000};
        ld_byte     = rdata_shift[7:0];
        ld_half     = lat_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_code)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        timeout_hit = (state == BUSY) && !dmem_ack && (cnt == TIMEOUT - 8'd1);
        state_nxt   = state;
        case (state)
            IDLE:    if (access && !misalign) state_nxt = BUSY;
            BUSY:    if (dmem_ack || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     cnt <= 8'd0;
        else if (state != BUSY || dmem_ack || timeout_hit) cnt <= 8'd0;
        else                                         cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_adr       <= 30'd0;
            dmem_be        <= 4'd0;
            dmem_wdata     <= 32'd0;
            wbk_rd_reg_wb  <= 1'b0;
            rd_adr_wb      <= 5'd0;
            rd_data_wb     <= 32'd0;
            ma_fault       <= 1'b0;
            ma_fault_cause <= 4'd0;
            ma_fault_adr   <= 32'd0;
            lat_rd         <= 5'd0;
            lat_code       <= 3'd0;
            lat_a          <= 2'd0;
            lat_wbk        <= 1'b0;
            lat_st         <= 1'b0;
            lat_eff_adr    <= 32'd0;
        end else begin
            wbk_rd_reg_wb <= 1'b0;
            ma_fault      <= 1'b0;
            if (state == IDLE) begin
                if (!access) begin
                    if (wbk_rd_reg_ma && (rd_adr_ma != 5'd0)) begin
                        wbk_rd_reg_wb <= 1'b1;
                        rd_adr_wb     <= rd_adr_ma;
                        rd_data_wb    <= rd_data_ma;
                    end
                end else if (misalign) begin
                    ma_fault       <= 1'b1;
                    ma_fault_cause <= is_st ? 4'd6 : 4'd4;
                    ma_fault_adr   <= rd_data_ma;
                end else begin
                    dmem_req    <= 1'b1;
                    dmem_we     <= is_st;
                    dmem_adr    <= rd_data_ma[31:2];
                    dmem_be     <= be_calc;
                    dmem_wdata  <= wdata_calc;
                    lat_rd      <= rd_adr_ma;
                    lat_code    <= ldst_code_ma;
                    lat_a       <= a;
                    lat_wbk     <= is_ld & wbk_rd_reg_ma & (rd_adr_ma != 5'd0);
                    lat_st      <= is_st;
                    lat_eff_adr <= rd_data_ma;
                end
            end else if (dmem_ack) begin
                dmem_req <= 1'b0;
                if (!lat_st && lat_wbk) begin
                    wbk_rd_reg_wb <= 1'b1;
                    rd_adr_wb     <= lat_rd;
                    rd_data_wb    <= ld_data;
                end
            end else if (timeout_hit) begin
                dmem_req       <= 1'b0;
                ma_fault       <= 1'b1;
                ma_fault_cause <= lat_st ? 4'd7 : 4'd5;
                ma_fault_adr   <= lat_eff_adr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboard queues for writeback and fault pulses,
// one task per scenario, bus acknowledged by a bounded driver task.
module tb_mem_access;

    localparam logic [7:0] TO = 8'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        dmem_req, dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        ma_stall, wbk_rd_reg_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        ma_fault;
    logic [3:0]  ma_fault_cause;
    logic [31:0] ma_fault_adr;
    logic        dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [36:0] exp_q[$];
    logic [35:0] exp_f_q[$];
    logic [36:0] mon_wb;
    logic [35:0] mon_f;

    int          busy_cycles, req_cyc, ack_cyc;
    logic        req_seen, req_end, wb_seen, fault_seen;
    logic        cap_we;
    logic [29:0] cap_adr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
        .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ma_stall(ma_stall), .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb(rd_adr_wb),
        .rd_data_wb(rd_data_wb), .ma_fault(ma_fault), .ma_fault_cause(ma_fault_cause),
        .ma_fault_adr(ma_fault_adr), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (wbk_rd_reg_wb) begin
                checks++;
                if (ma_fault !== 1'b0) begin
                    failures++;
                    $display("FAIL wb_fault_overlap ma_fault=%b required 0", ma_fault);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected rd=%0d data=%h required no writeback", rd_adr_wb, rd_data_wb);
                end else begin
                    mon_wb = exp_q.pop_front();
                    if ({rd_adr_wb, rd_data_wb} !== mon_wb) begin
                        failures++;
                        $display("FAIL wb_data rd=%0d data=%h required rd=%0d data=%h",
                                 rd_adr_wb, rd_data_wb, mon_wb[36:32], mon_wb[31:0]);
                    end
                end
            end
            if (ma_fault) begin
                checks++;
                if (exp_f_q.size() == 0) begin
                    failures++;
                    $display("FAIL fault_unexpected cause=%0d adr=%h required no fault", ma_fault_cause, ma_fault_adr);
                end else begin
                    mon_f = exp_f_q.pop_front();
                    if ({ma_fault_cause, ma_fault_adr} !== mon_f) begin
                        failures++;
                        $display("FAIL fault_info cause=%0d adr=%h required cause=%0d adr=%h",
                                 ma_fault_cause, ma_fault_adr, mon_f[35:32], mon_f[31:0]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_ld_ma     = 1'b0;
        cmd_st_ma     = 1'b0;
        wbk_rd_reg_ma = 1'b0;
        rd_adr_ma     = 5'd0;
        rd_data_ma    = 32'd0;
        st_data_ma    = 32'd0;
        ldst_code_ma  = 3'd0;
    endtask

    // Issues one command, acknowledges in BUSY cycle ack_at (0 = never) and
    // returns at the first cycle with ma_stall low.
    task automatic access(input logic ld, input logic st, input logic wbk, input logic [4:0] rd,
                          input logic [31:0] adr, input logic [31:0] sdata, input logic [2:0] code,
                          input int ack_at, input logic [31:0] rdata);
        cmd_ld_ma     = ld;
        cmd_st_ma     = st;
        wbk_rd_reg_ma = wbk;
        rd_adr_ma     = rd;
        rd_data_ma    = adr;
        st_data_ma    = sdata;
        ldst_code_ma  = code;
        tick();
        clear_inputs();
        busy_cycles = 0;
        req_seen    = 1'b0;
        req_cyc     = -1;
        ack_cyc     = -1;
        for (int i = 0; i < 300; i++) begin
            if (!ma_stall) break;
            busy_cycles++;
            if (dmem_req && !req_seen) begin
                req_seen  = 1'b1;
                req_cyc   = cyc;
                cap_we    = dmem_we;
                cap_adr   = dmem_adr;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
            end
            if (busy_cycles == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                ack_cyc    = cyc;
            end
            tick();
            dmem_ack = 1'b0;
        end
        checks++;
        if (ma_stall) begin
            failures++;
            $display("FAIL access_bound ma_stall=%b after 300 cycles required 0", ma_stall);
        end
        req_end    = dmem_req;
        wb_seen    = wbk_rd_reg_wb;
        fault_seen = ma_fault;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) tick();
        checks++;
        if ({dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata, ma_stall, wbk_rd_reg_wb, rd_adr_wb,
             rd_data_wb, ma_fault, ma_fault_cause, ma_fault_adr, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs req=%b be=%b stall=%b wb=%b fault=%b state=%b required all 0",
                     dmem_req, dmem_be, ma_stall, wbk_rd_reg_wb, ma_fault, dbg_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        exp_q.push_back({5'd5, 32'h1234_5678});
        wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd5; rd_data_ma = 32'h1234_5678;
        tick();
        clear_inputs();
        checks++;
        if (wbk_rd_reg_wb !== 1'b1) begin
            failures++;
            $display("FAIL pass_latency wb=%b required 1", wbk_rd_reg_wb);
        end
        wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd0; rd_data_ma = 32'hDEAD_0000;
        tick();
        clear_inputs();
        checks++;
        if (wbk_rd_reg_wb !== 1'b0) begin
            failures++;
            $display("FAIL pass_rd0 wb=%b required 0", wbk_rd_reg_wb);
        end
        for (int i = 0; i < 20; i++) begin
            wbk_rd_reg_ma = 1'($urandom_range(0, 1));
            rd_adr_ma     = 5'($urandom_range(0, 31));
            rd_data_ma    = $urandom;
            if (wbk_rd_reg_ma && rd_adr_ma != 5'd0) exp_q.push_back({rd_adr_ma, rd_data_ma});
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_byte();
        exp_q.push_back({5'd3, 32'hFFFF_FF80});
        access(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0103, 32'd0, 3'b000, 2, 32'h80AA_BBCC);
        checks++;
        if ({cap_we, cap_be, cap_adr} !== {1'b0, 4'b1000, 30'h40}) begin
            failures++;
            $display("FAIL lb_bus we=%b be=%b adr=%h required we=0 be=1000 adr=40", cap_we, cap_be, cap_adr);
        end
        checks++;
        if (busy_cycles !== 2 || wb_seen !== 1'b1) begin
            failures++;
            $display("FAIL lb_stall stall_cycles=%0d wb=%b required 2 and 1", busy_cycles, wb_seen);
        end
        exp_q.push_back({5'd4, 32'h0000_0080});
        access(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0103, 32'd0, 3'b100, 1, 32'h80AA_BBCC);
        checks++;
        if (wb_seen !== 1'b1 || busy_cycles !== 1) begin
            failures++;
            $display("FAIL lbu_timing wb=%b stall_cycles=%0d required 1 and 1", wb_seen, busy_cycles);
        end
    endtask

    task automatic test_store_half();
        access(1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0202, 32'h0000_BEEF, 3'b001, 1, 32'd0);
        checks++;
        if ({cap_we, cap_be, cap_adr, cap_wdata} !== {1'b1, 4'b1100, 30'h80, 32'hBEEF_BEEF}) begin
            failures++;
            $display("FAIL sh_bus we=%b be=%b adr=%h wdata=%h required we=1 be=1100 adr=80 wdata=beefbeef",
                     cap_we, cap_be, cap_adr, cap_wdata);
        end
        checks++;
        if (wb_seen !== 1'b0 || fault_seen !== 1'b0) begin
            failures++;
            $display("FAIL sh_no_wb wb=%b fault=%b required 0 and 0", wb_seen, fault_seen);
        end
    endtask

    task automatic test_misalign();
        logic        ld_t[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] adr_t[4]  = '{32'h101, 32'h102, 32'h200, 32'h300};
        logic [2:0]  code_t[4] = '{3'b010, 3'b010, 3'b100, 3'b011};
        for (int i = 0; i < 4; i++) begin
            exp_f_q.push_back({(ld_t[i] ? 4'd4 : 4'd6), adr_t[i]});
            access(ld_t[i], !ld_t[i], 1'b1, 5'd6, adr_t[i], 32'h1111_2222, code_t[i], 1, 32'd0);
            checks++;
            if (req_seen !== 1'b0 || req_end !== 1'b0 || busy_cycles !== 0 || fault_seen !== 1'b1) begin
                failures++;
                $display("FAIL misalign_%0d req=%b stall_cycles=%0d fault=%b required 0 0 1",
                         i, req_seen | req_end, busy_cycles, fault_seen);
            end
        end
    endtask

    task automatic test_timeout();
        exp_f_q.push_back({4'd5, 32'h0000_0010});
        access(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0010, 32'd0, 3'b001, 0, 32'd0);
        checks++;
        if (busy_cycles !== int'(TO) || fault_seen !== 1'b1 || req_end !== 1'b0 || ma_stall !== 1'b0) begin
            failures++;
            $display("FAIL timeout_ld req_cycles=%0d fault=%b req=%b stall=%b required %0d 1 0 0",
                     busy_cycles, fault_seen, req_end, ma_stall, TO);
        end
        exp_f_q.push_back({4'd7, 32'h0000_0020});
        access(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0020, 32'h55, 3'b010, 0, 32'd0);
        checks++;
        if (busy_cycles !== int'(TO) || fault_seen !== 1'b1) begin
            failures++;
            $display("FAIL timeout_st req_cycles=%0d fault=%b required %0d 1", busy_cycles, fault_seen, TO);
        end
        exp_q.push_back({5'd8, 32'hFFFF_8001});
        access(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0010, 32'd0, 3'b001, int'(TO), 32'h0000_8001);
        checks++;
        if (wb_seen !== 1'b1 || fault_seen !== 1'b0 || busy_cycles !== int'(TO)) begin
            failures++;
            $display("FAIL ack_at_timeout wb=%b fault=%b cycles=%0d required 1 0 %0d",
                     wb_seen, fault_seen, busy_cycles, TO);
        end
    endtask

    task automatic test_random_loads();
        logic [2:0]  codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  code;
        logic [31:0] adr, rdata, exp_d;
        logic [3:0]  exp_be;
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  rd;
        int          sh, ack_at;
        for (int i = 0; i < 10; i++) begin
            code   = codes[$urandom_range(0, 4)];
            sh     = (code[1:0] == 2'b00) ? $urandom_range(0, 3) :
                     (code[1:0] == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
            adr    = ($urandom & 32'hFFFF_FFFC) | 32'(sh);
            rdata  = $urandom;
            rd     = 5'($urandom_range(1, 31));
            ack_at = $urandom_range(1, 3);
            b      = rdata[8*sh +: 8];
            h      = rdata[8*sh +: 16];
            case (code)
                3'b000:  begin exp_d = {{24{b[7]}}, b};  exp_be = 4'b0001 << sh; end
                3'b001:  begin exp_d = {{16{h[15]}}, h}; exp_be = 4'b0011 << sh; end
                3'b100:  begin exp_d = {24'd0, b};       exp_be = 4'b0001 << sh; end
                3'b101:  begin exp_d = {16'd0, h};       exp_be = 4'b0011 << sh; end
                default: begin exp_d = rdata;            exp_be = 4'b1111; end
            endcase
            exp_q.push_back({rd, exp_d});
            access(1'b1, 1'b0, 1'b1, rd, adr, 32'd0, code, ack_at, rdata);
            checks++;
            if (cap_be !== exp_be || cap_adr !== adr[31:2] || busy_cycles !== ack_at || wb_seen !== 1'b1) begin
                failures++;
                $display("FAIL rand_load_%0d be=%b adr=%h cycles=%0d wb=%b required be=%b adr=%h cycles=%0d wb=1",
                         i, cap_be, cap_adr, busy_cycles, wb_seen, exp_be, adr[31:2], ack_at);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        cmd_ld_ma = 1'b1; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd7;
        rd_data_ma = 32'h0000_0300; ldst_code_ma = 3'b010;
        tick();
        clear_inputs();
        checks++;
        if (dmem_req !== 1'b1 || dbg_state !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy req=%b state=%b required 1 1", dmem_req, dbg_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || ma_stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_async req=%b stall=%b required 0 0", dmem_req, ma_stall);
        end
        tick();
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0;
        tick();
        checks++;
        if ({dmem_req, ma_stall, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, ma_fault, dbg_state} !== '0) begin
            failures++;
            $display("FAIL rst_late_ack req=%b stall=%b wb=%b rd=%0d data=%h state=%b required all 0",
                     dmem_req, ma_stall, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        int first_ack;
        access(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0400, 32'hA5A5_5A5A, 3'b010, 1, 32'd0);
        first_ack = ack_cyc;
        checks++;
        if (cap_we !== 1'b1 || cap_wdata !== 32'hA5A5_5A5A || cap_be !== 4'b1111) begin
            failures++;
            $display("FAIL b2b_sw we=%b wdata=%h be=%b required 1 a5a55a5a 1111", cap_we, cap_wdata, cap_be);
        end
        exp_q.push_back({5'd12, 32'h0BAD_BEEF});
        access(1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0404, 32'd0, 3'b010, 1, 32'h0BAD_BEEF);
        checks++;
        if (req_cyc - first_ack !== 2 || cap_we !== 1'b0 || cap_adr !== 30'h101) begin
            failures++;
            $display("FAIL b2b_lw req_gap=%0d we=%b adr=%h required 2 0 101", req_cyc - first_ack, cap_we, cap_adr);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_timeout();
        test_random_loads();
        test_back_to_back();
        test_reset_mid_busy();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0 || exp_f_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain wb_left=%0d fault_left=%0d required 0 0", exp_q.size(), exp_f_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
